cu_seq: RTL and testbench

CU_SEQ -- requirements
Module: cu_seq

---
 rtl/cu_seq.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_cu_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_seq.sv
// cu_seq: control-unit sequencer for a small accumulator CPU.
// Steps through FETCH (steps 0-4) and EXEC (steps 5-7). Each step raises
// the datapath strobes for the current instruction.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   cpu_run, busy         run enable / downstream stall (either one freezes the sequencer)
//   resume                single-cycle pulse that leaves HALT
//   opcode, operand       current instruction (CIR) and its operand (AR)
//   flags                 {Z,N,C,V}
//   pc_* .. uart_send     one-bit datapath strobes
//   reg_in, reg_out       one-hot register-file write/read strobes (bit 2 is the accumulator, tied 0)
//   step, state           current step and state (IDLE=0, FETCH=1, EXEC=2, HALT=3)
//   halted, illegal       in HALT / sticky illegal-instruction flag
module cu_seq #(
    parameter int         NREG      = 8,
    parameter int         STEP_W    = 4,
    parameter logic [7:0] UART_ADDR = 8'hFE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_run,
    input  logic              busy,
    input  logic              resume,
    input  logic [7:0]        opcode,
    input  logic [7:0]        operand,
    input  logic [3:0]        flags,
    output logic              pc_out,
    output logic              pc_inc,
    output logic              pc_in,
    output logic              mar_in,
    output logic              mdr_in,
    output logic              cir_in,
    output logic              cir_out,
    output logic              ar_in,
    output logic              ar_out,
    output logic              ram_in,
    output logic              ram_out,
    output logic              flag_in,
    output logic              acc_in,
    output logic              acc_out,
    output logic              acc_sel,
    output logic              uart_load,
    output logic              uart_send,
    output logic [NREG-1:0]   reg_in,
    output logic [NREG-1:0]   reg_out,
    output logic [STEP_W-1:0] step,
    output logic [1:0]        state,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0]        NREG_LIM = 4'(NREG);
    localparam logic [STEP_W-1:0] STEP_0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] STEP_1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] STEP_3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] STEP_4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] STEP_5   = STEP_W'(5);
    localparam logic [STEP_W-1:0] STEP_6   = STEP_W'(6);
    localparam logic [STEP_W-1:0] STEP_7   = STEP_W'(7);

    // Branch condition for JMP/Jcc; flags = {Z,N,C,V}.
    function automatic logic jcc_taken(input logic [7:0] op, input logic [3:0] f);
        case (op)
            8'h14:   jcc_taken = 1'b1;
            8'h15:   jcc_taken = f[3];
            8'h16:   jcc_taken = ~f[3];
            8'h17:   jcc_taken = f[1];
            8'h18:   jcc_taken = ~f[1];
            8'h19:   jcc_taken = ~f[2];
            8'h1A:   jcc_taken = f[2];
            8'h1B:   jcc_taken = f[0];
            8'h1C:   jcc_taken = ~f[0];
            default: jcc_taken = 1'b0;
        endcase
    endfunction

    // One-hot register strobe. Index 2 is the accumulator, so it never shows here.
    function automatic logic [7:0] onehot_reg(input logic [2:0] idx);
        onehot_reg = (8'd1 << idx) & 8'hFB;
    endfunction

    state_t              state_r;
    logic [STEP_W-1:0]   step_r;
    logic                illegal_r;

    logic [1:0]          mode_s;
    logic [2:0]          dest_s;
    logic [2:0]          src_s;
    logic                opnd_ok_s;
    logic                is_uart_s;
    logic                run_s;
    logic                active_s;
    logic                dec_acc_in_s;
    logic                dec_acc_out_s;
    logic [7:0]          dec_reg_in_s;
    logic [7:0]          dec_reg_out_s;
    logic [7:0]          reg_in8_s;
    logic [7:0]          reg_out8_s;
    logic                illegal_s;
    logic                is_hlt_s;
    logic [STEP_W-1:0]   end_step_s;
    logic                last_s;

    assign mode_s    = operand[7:6];
    assign dest_s    = operand[5:3];
    assign src_s     = operand[2:0];
    assign opnd_ok_s = (mode_s == 2'b01) && ({1'b0, dest_s} < NREG_LIM) && ({1'b0, src_s} < NREG_LIM);
    assign is_uart_s = (operand == UART_ADDR);
    assign is_hlt_s  = (opcode == 8'h0E);
    assign run_s     = cpu_run & ~busy;
    assign active_s  = run_s & ((state_r == ST_FETCH) || (state_r == ST_EXEC));

    // Register-operand decode. It is already gated by operand legality, so an
    // illegal operand produces no strobes.
    assign dec_acc_in_s  = opnd_ok_s && (dest_s == 3'd2);
    assign dec_acc_out_s = opnd_ok_s && (src_s == 3'd2);
    assign dec_reg_in_s  = opnd_ok_s ? onehot_reg(dest_s) : 8'h00;
    assign dec_reg_out_s = opnd_ok_s ? onehot_reg(src_s) : 8'h00;

    assign reg_in  = reg_in8_s[NREG-1:0];
    assign reg_out = reg_out8_s[NREG-1:0];
    assign step    = step_r;
    assign state   = state_r;
    assign halted  = (state_r == ST_HALT);
    assign illegal = illegal_r;

    // Instruction classification: legality and the final EXEC step of each opcode.
    always_comb begin
        illegal_s  = 1'b0;
        end_step_s = STEP_5;
        case (opcode) inside
            [8'h00:8'h05]: begin
                illegal_s  = ~opnd_ok_s;
                end_step_s = opnd_ok_s ? STEP_7 : STEP_5;
            end
            [8'h06:8'h0C]: end_step_s = STEP_7;
            8'h0D:         end_step_s = STEP_5;
            8'h0E:         end_step_s = STEP_5;
            8'h0F:         end_step_s = STEP_7;
            8'h10:         end_step_s = is_uart_s ? STEP_7 : STEP_5;
            8'h11:         illegal_s  = ~opnd_ok_s;
            8'h12: begin
                illegal_s  = ~opnd_ok_s;
                end_step_s = opnd_ok_s ? STEP_6 : STEP_5;
            end
            8'h13:         end_step_s = STEP_6;
            [8'h14:8'h1C]: end_step_s = STEP_5;
            default:       illegal_s  = 1'b1;
        endcase
    end

    // A step at or beyond the final step also returns to FETCH.
    assign last_s = (step_r >= end_step_s);

    // Strobe decode. Everything is 0 outside FETCH/EXEC and while frozen.
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_in      = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        cir_in     = 1'b0;
        cir_out    = 1'b0;
        ar_in      = 1'b0;
        ar_out     = 1'b0;
        ram_in     = 1'b0;
        ram_out    = 1'b0;
        flag_in    = 1'b0;
        acc_in     = 1'b0;
        acc_out    = 1'b0;
        acc_sel    = 1'b0;
        uart_load  = 1'b0;
        uart_send  = 1'b0;
        reg_in8_s  = 8'h00;
        reg_out8_s = 8'h00;
        if (active_s && (state_r == ST_FETCH)) begin
            case (step_r)
                STEP_0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                STEP_1: mdr_in = 1'b1;
                STEP_2: cir_in = 1'b1;
                STEP_3: pc_inc = 1'b1;
                STEP_4: begin
                    cir_out = 1'b1;
                    ar_in   = 1'b1;
                end
                default: pc_out = 1'b0;
            endcase
        end else if (active_s && (state_r == ST_EXEC)) begin
            case (step_r)
                STEP_5: begin
                    case (opcode) inside
                        [8'h00:8'h05], 8'h11, 8'h12: begin
                            acc_in     = dec_acc_in_s;
                            acc_out    = dec_acc_out_s;
                            reg_in8_s  = dec_reg_in_s;
                            reg_out8_s = dec_reg_out_s;
                            acc_sel    = (opcode == 8'h12) && opnd_ok_s;
                        end
                        [8'h06:8'h0C]: acc_in = 1'b1;
                        8'h0F:         ram_out = 1'b1;
                        8'h10: begin
                            acc_out   = 1'b1;
                            uart_load = is_uart_s;
                            ram_in    = ~is_uart_s;
                        end
                        8'h13: begin
                            ar_out  = 1'b1;
                            acc_sel = 1'b1;
                            acc_in  = 1'b1;
                        end
                        [8'h14:8'h1C]: begin
                            // Flags only matter here; they are ignored on every other step.
                            ar_out = jcc_taken(opcode, flags);
                            pc_in  = jcc_taken(opcode, flags);
                        end
                        default: acc_in = 1'b0;
                    endcase
                end
                STEP_6: begin
                    case (opcode) inside
                        [8'h00:8'h0C], 8'h12, 8'h13: flag_in = 1'b1;
                        8'h0F: begin
                            ram_out = 1'b1;
                            acc_in  = 1'b1;
                            acc_sel = 1'b1;
                        end
                        8'h10:   uart_send = is_uart_s;
                        default: flag_in = 1'b0;
                    endcase
                end
                STEP_7: flag_in = (opcode == 8'h0F);
                default: flag_in = 1'b0;
            endcase
        end else begin
            pc_out = 1'b0;
        end
    end

    // Sequencer state machine: state, step counter and sticky illegal flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            step_r    <= STEP_0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_run) begin
                        state_r <= ST_FETCH;
                        step_r  <= STEP_0;
                    end
                end
                ST_FETCH: begin
                    if (run_s) begin
                        if (step_r >= STEP_4) begin
                            state_r <= ST_EXEC;
                            step_r  <= STEP_5;
                        end else begin
                            step_r <= step_r + STEP_1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (run_s) begin
                        if ((step_r == STEP_5) && illegal_s) begin
                            illegal_r <= 1'b1;
                        end
                        // HALT keeps step at 5; it leaves only on resume.
                        if ((step_r == STEP_5) && is_hlt_s) begin
                            state_r <= ST_HALT;
                        end else if (last_s) begin
                            state_r <= ST_FETCH;
                            step_r  <= STEP_0;
                        end else begin
                            step_r <= step_r + STEP_1;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_r <= ST_FETCH;
                        step_r  <= STEP_0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    step_r  <= STEP_0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_seq.sv
// Scoreboard bench for cu_seq. For each instruction the driver builds the
// expected per-cycle trace from the instruction's step table and pushes one
// record per cycle. A negedge monitor pops the records and compares them
// with the DUT outputs.
module tb_cu_seq;

    logic       clk = 1'b0;
    logic       reset_n, cpu_run, busy, resume;
    logic [7:0] opcode, operand;
    logic [3:0] flags;
    logic pc_out, pc_inc, pc_in, mar_in, mdr_in, cir_in, cir_out, ar_in, ar_out;
    logic ram_in, ram_out, flag_in, acc_in, acc_out, acc_sel, uart_load, uart_send;
    logic [7:0] reg_in, reg_out;
    logic [3:0] step;
    logic [1:0] state;
    logic       halted, illegal;

    cu_seq dut (
        .clk(clk), .reset_n(reset_n), .cpu_run(cpu_run), .busy(busy), .resume(resume),
        .opcode(opcode), .operand(operand), .flags(flags),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .cir_in(cir_in), .cir_out(cir_out), .ar_in(ar_in), .ar_out(ar_out),
        .ram_in(ram_in), .ram_out(ram_out), .flag_in(flag_in), .acc_in(acc_in),
        .acc_out(acc_out), .acc_sel(acc_sel), .uart_load(uart_load), .uart_send(uart_send),
        .reg_in(reg_in), .reg_out(reg_out), .step(step), .state(state),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] M_PC_OUT    = 17'h00001;
    localparam logic [16:0] M_PC_INC    = 17'h00002;
    localparam logic [16:0] M_PC_IN     = 17'h00004;
    localparam logic [16:0] M_MAR_IN    = 17'h00008;
    localparam logic [16:0] M_MDR_IN    = 17'h00010;
    localparam logic [16:0] M_CIR_IN    = 17'h00020;
    localparam logic [16:0] M_CIR_OUT   = 17'h00040;
    localparam logic [16:0] M_AR_IN     = 17'h00080;
    localparam logic [16:0] M_AR_OUT    = 17'h00100;
    localparam logic [16:0] M_RAM_IN    = 17'h00200;
    localparam logic [16:0] M_RAM_OUT   = 17'h00400;
    localparam logic [16:0] M_FLAG_IN   = 17'h00800;
    localparam logic [16:0] M_ACC_IN    = 17'h01000;
    localparam logic [16:0] M_ACC_OUT   = 17'h02000;
    localparam logic [16:0] M_ACC_SEL   = 17'h04000;
    localparam logic [16:0] M_UART_LOAD = 17'h08000;
    localparam logic [16:0] M_UART_SEND = 17'h10000;

    typedef struct packed {
        logic [16:0] s;
        logic [7:0]  ri;
        logic [7:0]  ro;
    } word_t;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] stp;
        word_t      w;
        logic       hlt;
        logic       ill;
    } rec_t;

    rec_t  exp_q[$];
    word_t plan[$];
    bit    plan_ill, plan_halt;
    bit    m_ill;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] act_strobes();
        return {uart_send, uart_load, acc_sel, acc_out, acc_in, flag_in, ram_out, ram_in,
                ar_out, ar_in, cir_out, cir_in, mdr_in, mar_in, pc_in, pc_inc, pc_out};
    endfunction

    function automatic word_t mk(input logic [16:0] s);
        word_t w;
        w   = '0;
        w.s = s;
        return w;
    endfunction

    // Register-operand effect: dest is written, src is read; index 2 is the accumulator.
    function automatic word_t opnd_word(input logic [7:0] o);
        word_t w;
        w = '0;
        if (o[5:3] == 3'd2) w.s = w.s | M_ACC_IN;  else w.ri[o[5:3]] = 1'b1;
        if (o[2:0] == 3'd2) w.s = w.s | M_ACC_OUT; else w.ro[o[2:0]] = 1'b1;
        return w;
    endfunction

    // Expected EXEC steps (5, 6, 7...) for one instruction.
    task automatic build_plan(input logic [7:0] op, input logic [7:0] o, input logic [3:0] fl);
        bit    ok, take;
        word_t d;
        ok = (o[7:6] == 2'b01);
        d  = opnd_word(o);
        plan.delete();
        plan_ill  = 1'b0;
        plan_halt = 1'b0;
        case (op)
            8'h14: take = 1'b1;
            8'h15: take = fl[3];
            8'h16: take = !fl[3];
            8'h17: take = fl[1];
            8'h18: take = !fl[1];
            8'h19: take = !fl[2];
            8'h1A: take = fl[2];
            8'h1B: take = fl[0];
            8'h1C: take = !fl[0];
            default: take = 1'b0;
        endcase
        if (op <= 8'h05) begin
            if (ok) begin plan.push_back(d); plan.push_back(mk(M_FLAG_IN)); plan.push_back(mk(17'h0)); end
            else plan_ill = 1'b1;
        end else if (op <= 8'h0C) begin
            plan.push_back(mk(M_ACC_IN)); plan.push_back(mk(M_FLAG_IN)); plan.push_back(mk(17'h0));
        end else if (op == 8'h0D) begin
            plan.push_back(mk(17'h0));
        end else if (op == 8'h0E) begin
            plan_halt = 1'b1;
            plan.push_back(mk(17'h0));
        end else if (op == 8'h0F) begin
            plan.push_back(mk(M_RAM_OUT));
            plan.push_back(mk(M_RAM_OUT | M_ACC_IN | M_ACC_SEL));
            plan.push_back(mk(M_FLAG_IN));
        end else if (op == 8'h10) begin
            if (o == 8'hFE) begin
                plan.push_back(mk(M_ACC_OUT | M_UART_LOAD)); plan.push_back(mk(M_UART_SEND)); plan.push_back(mk(17'h0));
            end else plan.push_back(mk(M_ACC_OUT | M_RAM_IN));
        end else if (op == 8'h11) begin
            if (ok) plan.push_back(d); else plan_ill = 1'b1;
        end else if (op == 8'h12) begin
            d.s = d.s | M_ACC_SEL;
            if (ok) begin plan.push_back(d); plan.push_back(mk(M_FLAG_IN)); end
            else plan_ill = 1'b1;
        end else if (op == 8'h13) begin
            plan.push_back(mk(M_AR_OUT | M_ACC_SEL | M_ACC_IN)); plan.push_back(mk(M_FLAG_IN));
        end else if (op <= 8'h1C) begin
            plan.push_back(take ? mk(M_AR_OUT | M_PC_IN) : mk(17'h0));
        end else begin
            plan_ill = 1'b1;
        end
        if (plan_ill) plan.push_back(mk(17'h0));
    endtask

    // One clock cycle: drive the inputs just after the edge and queue the expected record for that cycle.
    task automatic drive(input logic run, input logic bsy, input logic res, input logic [3:0] fl,
                         input logic [7:0] op, input logic [7:0] o, input rec_t r);
        @(posedge clk);
        #1;
        cpu_run = run; busy = bsy; resume = res; flags = fl; opcode = op; operand = o;
        exp_q.push_back(r);
    endtask

    task automatic idle_cyc(input logic run);
        rec_t r;
        r = '0;
        r.ill = m_ill;
        drive(run, 1'b0, 1'b0, 4'($urandom), 8'h00, 8'h00, r);
    endtask

    task automatic release_rst(input logic run);
        rec_t r;
        repeat (2) @(posedge clk);
        #2;
        cpu_run = run; busy = 1'b0; resume = 1'b0;
        reset_n = 1'b1;
        r = '0;
        exp_q.push_back(r);
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [7:0] o, input logic [3:0] fl,
                             input bit rand_frz, input int busy_at, input int busy_n, input int rst_at);
        word_t all[$];
        rec_t  r;
        int    nf;
        build_plan(op, o, fl);
        all.push_back(mk(M_PC_OUT | M_MAR_IN));
        all.push_back(mk(M_MDR_IN));
        all.push_back(mk(M_CIR_IN));
        all.push_back(mk(M_PC_INC));
        all.push_back(mk(M_CIR_OUT | M_AR_IN));
        foreach (plan[k]) all.push_back(plan[k]);
        for (int i = 0; i < all.size(); i++) begin
            r     = '0;
            r.st  = (i < 5) ? 2'd1 : 2'd2;
            r.stp = 4'(i);
            r.ill = m_ill;
            if (i == busy_at) begin
                for (int b = 0; b < busy_n; b++) drive(1'b1, 1'b1, 1'b0, 4'($urandom), op, o, r);
            end else if (rand_frz && ($urandom_range(0, 7) == 0)) begin
                nf = int'($urandom_range(1, 3));
                for (int b = 0; b < nf; b++) begin
                    if ($urandom_range(0, 1) == 0) drive(1'b0, 1'($urandom), 1'b0, 4'($urandom), op, o, r);
                    else drive(1'($urandom), 1'b1, 1'b0, 4'($urandom), op, o, r);
                end
            end
            r.w = all[i];
            drive(1'b1, 1'b0, 1'b0, (i == 5) ? fl : 4'($urandom), op, o, r);
            if (i == rst_at) begin
                #6;
                reset_n = 1'b0;
                #1;
                chk("rst_acc_in", 32'(acc_in), 32'd0);
                chk("rst_strobes", 32'(act_strobes()), 32'd0);
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_step", 32'(step), 32'd0);
                chk("rst_illegal", 32'(illegal), 32'd0);
                m_ill = 1'b0;
                return;
            end
            if (i == 5 && plan_ill) m_ill = 1'b1;
        end
        if (plan_halt) begin
            for (int k = 0; k < 4; k++) begin
                r     = '0;
                r.st  = 2'd3;
                r.stp = 4'd5;
                r.hlt = 1'b1;
                r.ill = m_ill;
                drive(1'($urandom), 1'($urandom), (k == 3), 4'($urandom), op, o, r);
            end
        end
    endtask

    // Scoreboard monitor: compares one expected record per cycle, away from the active edge.
    always @(negedge clk) begin
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("step", 32'(step), 32'(e.stp));
            chk("strobes", 32'(act_strobes()), 32'(e.w.s));
            chk("reg_in", 32'(reg_in), 32'(e.w.ri));
            chk("reg_out", 32'(reg_out), 32'(e.w.ro));
            chk("halted", 32'(halted), 32'(e.hlt));
            chk("illegal", 32'(illegal), 32'(e.ill));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d records pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rop, ro;
        reset_n = 1'b0; cpu_run = 1'b1; busy = 1'b0; resume = 1'b0;
        opcode = 8'h00; operand = 8'h00; flags = 4'h0;
        m_ill = 1'b0;
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_strobes", 32'(act_strobes()), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);

        release_rst(1'b1);
        run_instr(8'h00, 8'h48, 4'h0, 1'b0, -1, 0, -1);       // ADD R1 <- R0
        run_instr(8'h15, 8'h33, 4'b0000, 1'b0, -1, 0, -1);    // JZ, Z=0: not taken
        run_instr(8'h15, 8'h33, 4'b1000, 1'b0, -1, 0, -1);    // JZ, Z=1: taken
        run_instr(8'h10, 8'hFE, 4'h0, 1'b0, 7, 3, -1);        // STORE to UART, busy at step 7
        run_instr(8'h10, 8'h40, 4'h0, 1'b0, -1, 0, -1);       // STORE to RAM
        run_instr(8'h0E, 8'h00, 4'h0, 1'b0, -1, 0, -1);       // HLT then resume
        run_instr(8'h3F, 8'h48, 4'h0, 1'b0, -1, 0, -1);       // undefined opcode
        run_instr(8'h00, 8'h08, 4'h0, 1'b0, -1, 0, -1);       // ADD with mode 00
        run_instr(8'h12, 8'h50, 4'h0, 1'b0, -1, 0, -1);       // MOV C,Rs src=acc? dest 2
        run_instr(8'h0F, 8'h20, 4'h0, 1'b0, -1, 0, -1);       // LOAD

        for (int n = 0; n < 150; n++) begin
            rop = 8'($urandom_range(0, 31));
            ro  = 8'($urandom);
            if ($urandom_range(0, 5) != 0) ro[7:6] = 2'b01;
            if (rop == 8'h10 && $urandom_range(0, 1) == 1) ro = 8'hFE;
            run_instr(rop, ro, 4'($urandom), 1'b1,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                      int'($urandom_range(1, 3)), -1);
        end

        run_instr(8'h0F, 8'h00, 4'h0, 1'b0, -1, 0, 6);        // reset during LOAD step 6
        release_rst(1'b0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);
        idle_cyc(1'b1);
        run_instr(8'h13, 8'h7C, 4'h0, 1'b0, -1, 0, -1);       // MOVI
        run_instr(8'h11, 8'h7A, 4'h0, 1'b0, -1, 0, -1);       // MOV R7 <- C

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
